channelizer_avg_ctrl: RTL and testbench
=======================================

// Module: channelizer_avg_ctrl
// PURPOSE
//   Sequencer for the channelizer binning/averaging datapath. Tracks FFT frame starts (fft_ready) and
//   counts bins and frames. Drives the accumulator clear/enable/address controls, and hands each
//   completed N_AVGS-frame average to the Ethernet packetizer over a valid/ready handshake.
//   Drops and flags frames that arrive while the previous average is still waiting to be read.
// PARAMETERS
//   BINS       4    bins per FFT frame (>=2); one bin per clk after fft_ready
//   AVG_W      8    width of N_AVGS_in and frame counters
//   DROP_W     16   width of saturating dropped-frame counter
// PORTS
//   clk          in   1                  system clock
//   rst          in   1                  synchronous reset, active-high
//   fft_ready    in   1                  frame-start strobe; in_data of that cycle is bin 0
//   N_AVGS_in    in   AVG_W              frames per average; sampled at start of each average period
//   acc_en       out  1                  accumulator write enable (bin valid)
//   acc_clear    out  1                  with acc_en: write sample instead of add (first frame of period)
//   bin_addr     out  $clog2(BINS)       accumulator bin index
//   frame_idx    out  AVG_W              frame number within current period, 0-based
//   out_valid    out  1                  averaged spectrum complete, held until out_ready
//   out_ready    in   1                  downstream consumed averaged spectrum
//   frame_drop   out  1                  1-cycle pulse: frame rejected (DUMP state)
//   frame_err    out  1                  1-cycle pulse: fft_ready inside a running frame
//   drop_count   out  DROP_W             saturating count of dropped frames
//   busy         out  1                  state != IDLE
// BEHAVIOUR
//   Reset: state IDLE. All outputs 0. drop_count=0. navg_q=1. Reset mid-frame abandons the period; no out_valid.
//   Latency: control outputs are registered. fft_ready sampled at cycle k -> acc_en=1 for cycles
//     k+1..k+BINS with bin_addr 0..BINS-1. The datapath delays in_data by one register to align.
//   navg_q <= (N_AVGS_in==0) ? 1 : N_AVGS_in. Latched only on a fft_ready that starts a new period
//     (from IDLE, or the accepting cycle in DUMP). Mid-period changes of N_AVGS_in are ignored.
//   States:
//     IDLE  : fft_ready -> ACCUM. Latch navg_q. frame_cnt=0. bin_cnt=0. Next frame is first of period.
//     ACCUM : emits one bin per cycle. acc_clear=1 for all BINS cycles of frame 0, else 0.
//             At the last bin (bin_cnt==BINS-1):
//               if frame_cnt==navg_q-1 -> DUMP. out_valid=1 from the following cycle.
//               else frame_cnt+1 and wait for the next fft_ready; acc_en=0 while waiting.
//             fft_ready on the cycle the last bin is issued, or later, starts the next frame normally.
//             fft_ready while bin_cnt in 1..BINS-1 (i.e. a frame is mid-emission):
//               pulse frame_err, abort the period, restart as frame 0 (acc_clear) at bin 0.
//     DUMP  : out_valid=1, acc_en=0.
//             out_valid&&out_ready -> IDLE next cycle; out_valid drops.
//             If fft_ready is high in the same cycle, that frame is accepted: new period, ACCUM.
//             fft_ready without out_ready -> frame ignored. frame_drop pulses.
//               drop_count+1, saturating at 2^DROP_W-1.
//   frame_idx = frame_cnt while ACCUM, else 0. busy = (state!=IDLE).
//   out_ready outside DUMP is ignored. out_valid never drops without handshake except on rst.
// TESTING
//   1 reset: rst=1 two cycles -> all outputs 0, busy=0; N_AVGS_in=1, fft_ready@k ->
//     acc_en k+1..k+4, bin_addr 0,1,2,3, acc_clear=1, out_valid=1 at k+5.
//   2 N_AVGS_in=3, three frames, gap 2 cycles, out_ready=1 -> acc_clear only on frame 0;
//     frame_idx 0,1,2; single out_valid cycle after 12th bin.
//   3 N_AVGS_in=1, out_ready=0, two more fft_ready in DUMP -> 2 frame_drop pulses, drop_count=2,
//     out_valid held; then out_ready=1 with fft_ready same cycle -> ACCUM, acc_clear=1.
//   4 fft_ready reasserted at bin_addr=2 -> frame_err pulse; next cycles bin_addr 0..3 with acc_clear=1;
//     out_valid only after the full restarted period.
//   5 N_AVGS_in=0 -> behaves as 1; change N_AVGS_in 2->5 mid-period -> current period still 2 frames.
//   6 rst asserted at frame_cnt=1, bin 2 -> next cycle all outputs 0, IDLE, drop_count cleared.

Source files
------------

// File: rtl/channelizer_avg_ctrl_if.sv
// Control bundle between the channelizer averaging sequencer and the blocks around it:
// frame-start input, accumulator controls, averaged-spectrum handshake and drop/error status.
interface channelizer_avg_ctrl_if #(
    parameter int BINS   = 4,
    parameter int AVG_W  = 8,
    parameter int DROP_W = 16
);
    localparam int BW = $clog2(BINS);

    logic              fft_ready;
    logic [AVG_W-1:0]  N_AVGS_in;
    logic              acc_en;
    logic              acc_clear;
    logic [BW-1:0]     bin_addr;
    logic [AVG_W-1:0]  frame_idx;
    logic              out_valid;
    logic              out_ready;
    logic              frame_drop;
    logic              frame_err;
    logic [DROP_W-1:0] drop_count;
    logic              busy;

    modport master (
        input  fft_ready, N_AVGS_in, out_ready,
        output acc_en, acc_clear, bin_addr, frame_idx, out_valid,
               frame_drop, frame_err, drop_count, busy
    );

    modport slave (
        output fft_ready, N_AVGS_in, out_ready,
        input  acc_en, acc_clear, bin_addr, frame_idx, out_valid,
               frame_drop, frame_err, drop_count, busy
    );
endinterface

// File: rtl/channelizer_avg_ctrl.sv
// Sequencer for the channelizer binning/averaging datapath: walks bins of each FFT frame,
// counts frames per average period and hands finished averages downstream on valid/ready.
module channelizer_avg_ctrl #(
    parameter int BINS   = 4,
    parameter int AVG_W  = 8,
    parameter int DROP_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    channelizer_avg_ctrl_if.master bus
);
    localparam int BW = $clog2(BINS);
    localparam logic [BW-1:0] LAST_BIN = BW'(BINS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DUMP  = 2'd2;

    // A zero frame count would never complete a period, so it is treated as one frame.
    function automatic logic [AVG_W-1:0] navg_sel(input logic [AVG_W-1:0] n);
        return (n == '0) ? AVG_W'(1) : n;
    endfunction

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + DROP_W'(1);
    endfunction

    logic [1:0]        state_p0,      state_p1;
    logic              acc_en_p0,     acc_en_p1;
    logic              acc_clear_p0,  acc_clear_p1;
    logic [BW-1:0]     bin_addr_p0,   bin_addr_p1;
    logic [AVG_W-1:0]  frame_cnt_p0,  frame_cnt_p1;
    logic [AVG_W-1:0]  navg_p0,       navg_p1;
    logic              out_valid_p0,  out_valid_p1;
    logic              frame_drop_p0, frame_drop_p1;
    logic              frame_err_p0,  frame_err_p1;
    logic [DROP_W-1:0] drop_count_p0, drop_count_p1;

    // Stage p0: next control values from current state and this cycle's inputs
    always_comb begin
        state_p0      = state_p1;
        acc_en_p0     = 1'b0;
        acc_clear_p0  = 1'b0;
        bin_addr_p0   = '0;
        frame_cnt_p0  = frame_cnt_p1;
        navg_p0       = navg_p1;
        out_valid_p0  = out_valid_p1;
        frame_drop_p0 = 1'b0;
        frame_err_p0  = 1'b0;
        drop_count_p0 = drop_count_p1;
        case (state_p1)
            IDLE: begin
                if (bus.fft_ready) begin
                    state_p0     = ACCUM;
                    navg_p0      = navg_sel(bus.N_AVGS_in);
                    frame_cnt_p0 = '0;
                    acc_en_p0    = 1'b1;
                    acc_clear_p0 = 1'b1;
                end
            end
            ACCUM: begin
                if (acc_en_p1) begin
                    if (bin_addr_p1 != LAST_BIN) begin
                        acc_en_p0 = 1'b1;
                        if (bus.fft_ready) begin
                            // New frame start while this one is still emitting: restart the period.
                            frame_err_p0 = 1'b1;
                            frame_cnt_p0 = '0;
                            acc_clear_p0 = 1'b1;
                        end else begin
                            bin_addr_p0  = bin_addr_p1 + BW'(1);
                            acc_clear_p0 = acc_clear_p1;
                        end
                    end else if (frame_cnt_p1 == navg_p1 - AVG_W'(1)) begin
                        state_p0     = DUMP;
                        out_valid_p0 = 1'b1;
                        frame_cnt_p0 = '0;
                    end else begin
                        frame_cnt_p0 = frame_cnt_p1 + AVG_W'(1);
                        acc_en_p0    = bus.fft_ready;
                    end
                end else if (bus.fft_ready) begin
                    acc_en_p0 = 1'b1;
                end
            end
            DUMP: begin
                if (bus.out_ready) begin
                    out_valid_p0 = 1'b0;
                    if (bus.fft_ready) begin
                        state_p0     = ACCUM;
                        navg_p0      = navg_sel(bus.N_AVGS_in);
                        frame_cnt_p0 = '0;
                        acc_en_p0    = 1'b1;
                        acc_clear_p0 = 1'b1;
                    end else begin
                        state_p0 = IDLE;
                    end
                end else if (bus.fft_ready) begin
                    frame_drop_p0 = 1'b1;
                    drop_count_p0 = sat_inc(drop_count_p1);
                end
            end
            default: state_p0 = IDLE;
        endcase
    end

    // Stage p1: registered control outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p1      <= IDLE;
            acc_en_p1     <= 1'b0;
            acc_clear_p1  <= 1'b0;
            bin_addr_p1   <= '0;
            frame_cnt_p1  <= '0;
            navg_p1       <= AVG_W'(1);
            out_valid_p1  <= 1'b0;
            frame_drop_p1 <= 1'b0;
            frame_err_p1  <= 1'b0;
            drop_count_p1 <= '0;
        end else begin
            state_p1      <= state_p0;
            acc_en_p1     <= acc_en_p0;
            acc_clear_p1  <= acc_clear_p0;
            bin_addr_p1   <= bin_addr_p0;
            frame_cnt_p1  <= frame_cnt_p0;
            navg_p1       <= navg_p0;
            out_valid_p1  <= out_valid_p0;
            frame_drop_p1 <= frame_drop_p0;
            frame_err_p1  <= frame_err_p0;
            drop_count_p1 <= drop_count_p0;
        end
    end

    assign bus.acc_en     = acc_en_p1;
    assign bus.acc_clear  = acc_clear_p1;
    assign bus.bin_addr   = bin_addr_p1;
    assign bus.frame_idx  = (state_p1 == ACCUM) ? frame_cnt_p1 : '0;
    assign bus.out_valid  = out_valid_p1;
    assign bus.frame_drop = frame_drop_p1;
    assign bus.frame_err  = frame_err_p1;
    assign bus.drop_count = drop_count_p1;
    assign bus.busy       = (state_p1 != IDLE);
endmodule

// File: tb/tb_channelizer_avg_ctrl.sv
// Bench for channelizer_avg_ctrl: directed scenarios then random traffic, every cycle compared
// against a timeline model (frame start time, frame number, period mode).
module tb_channelizer_avg_ctrl;
    localparam int BINS   = 4;
    localparam int AVG_W  = 8;
    localparam int DROP_W = 4;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    channelizer_avg_ctrl_if #(.BINS(BINS), .AVG_W(AVG_W), .DROP_W(DROP_W)) bus ();

    channelizer_avg_ctrl #(.BINS(BINS), .AVG_W(AVG_W), .DROP_W(DROP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: mode 0 idle, 1 inside a period, 2 holding a finished average.
    // fs is the edge on which the current frame started; bin visible after edge e is e-fs.
    int m_mode, m_fs, m_fnum, m_navg, m_drops, edge_n;
    bit m_wait, m_err, m_drop;

    task automatic model_start(input int nav);
        m_mode = 1; m_wait = 0; m_fs = edge_n; m_fnum = 0;
        m_navg = (nav == 0) ? 1 : nav;
    endtask

    task automatic model_edge(input bit fr, input int nav, input bit ordy, input bit r);
        int b;
        edge_n++;
        m_err = 0; m_drop = 0;
        if (r) begin
            m_mode = 0; m_wait = 0; m_drops = 0; m_fnum = 0; m_navg = 1;
            return;
        end
        if (m_mode == 0) begin
            if (fr) model_start(nav);
        end else if (m_mode == 1) begin
            if (!m_wait) begin
                b = edge_n - 1 - m_fs;
                if (b < BINS - 1) begin
                    if (fr) begin
                        m_err = 1; m_fs = edge_n; m_fnum = 0;
                    end
                end else if (m_fnum == m_navg - 1) begin
                    m_mode = 2;
                end else begin
                    m_fnum++;
                    if (fr) m_fs = edge_n;
                    else m_wait = 1;
                end
            end else if (fr) begin
                m_wait = 0; m_fs = edge_n;
            end
        end else begin
            if (ordy) begin
                if (fr) model_start(nav);
                else m_mode = 0;
            end else if (fr) begin
                m_drop = 1;
                if (m_drops != (1 << DROP_W) - 1) m_drops++;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h edge=%0d", tag, obs, exp, edge_n);
        end
    endtask

    task automatic compare_all();
        bit emit;
        emit = (m_mode == 1) && !m_wait;
        chk("acc_en",     32'(bus.acc_en),     32'(emit));
        chk("acc_clear",  32'(bus.acc_clear),  32'(emit && m_fnum == 0));
        chk("bin_addr",   32'(bus.bin_addr),   emit ? 32'(edge_n - m_fs) : 32'd0);
        chk("frame_idx",  32'(bus.frame_idx),  (m_mode == 1) ? 32'(m_fnum) : 32'd0);
        chk("out_valid",  32'(bus.out_valid),  32'(m_mode == 2));
        chk("frame_drop", 32'(bus.frame_drop), 32'(m_drop));
        chk("frame_err",  32'(bus.frame_err),  32'(m_err));
        chk("drop_count", 32'(bus.drop_count), 32'(m_drops));
        chk("busy",       32'(bus.busy),       32'(m_mode != 0));
    endtask

    task automatic step(input bit fr, input int nav, input bit ordy, input bit r);
        @(negedge clk);
        rst           = r;
        bus.fft_ready = fr;
        bus.N_AVGS_in = AVG_W'(nav);
        bus.out_ready = ordy;
        model_edge(fr, nav, ordy, r);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        rst = 1'b1; bus.fft_ready = 1'b0; bus.N_AVGS_in = '0; bus.out_ready = 1'b0;
        m_mode = 0; m_fs = 0; m_fnum = 0; m_navg = 1; m_drops = 0; edge_n = 0;
        m_wait = 0; m_err = 0; m_drop = 0;

        // Reset, then a single-frame average
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        step(1, 1, 0, 0);
        repeat (4) step(0, 1, 0, 0);
        chk("n1_out_valid", 32'(bus.out_valid), 32'd1);
        step(0, 1, 1, 0);

        // Three-frame average, 2-cycle gaps, out_ready held high
        for (int f = 0; f < 3; f++) begin
            step(1, 3, 1, 0);
            repeat (3) step(0, 3, 1, 0);
            repeat (2) step(0, 3, 1, 0);
        end

        // Frames arriving while the average is unread are dropped
        step(1, 1, 0, 0);
        repeat (4) step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("drops_two",      32'(bus.drop_count), 32'd2);
        chk("drops_held_vld", 32'(bus.out_valid),  32'd1);
        step(1, 1, 1, 0);
        chk("accept_clear", 32'(bus.acc_clear), 32'd1);
        repeat (4) step(0, 1, 0, 0);
        step(0, 1, 1, 0);

        // Frame start mid-emission aborts and restarts the period
        step(1, 2, 0, 0);
        step(0, 2, 0, 0);
        step(0, 2, 0, 0);
        step(1, 2, 0, 0);
        chk("err_pulse", 32'(bus.frame_err), 32'd1);
        repeat (3) step(0, 2, 0, 0);
        step(0, 2, 0, 0);
        step(1, 2, 0, 0);
        repeat (4) step(0, 2, 0, 0);
        step(0, 2, 1, 0);

        // N_AVGS_in of 0 acts as 1; mid-period change is ignored
        step(1, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0);
        chk("n0_out_valid", 32'(bus.out_valid), 32'd1);
        step(0, 0, 1, 0);
        step(1, 2, 0, 0);
        repeat (4) step(0, 5, 0, 0);
        step(1, 5, 0, 0);
        repeat (4) step(0, 5, 0, 0);
        chk("n2_held_period", 32'(bus.out_valid), 32'd1);
        step(0, 5, 1, 0);

        // Reset in the middle of the second frame
        step(1, 3, 0, 0);
        repeat (4) step(0, 3, 0, 0);
        step(1, 3, 0, 0);
        step(0, 3, 0, 0);
        step(0, 3, 0, 0);
        step(0, 3, 0, 1);
        chk("rst_mid_busy",  32'(bus.busy),       32'd0);
        chk("rst_mid_drops", 32'(bus.drop_count), 32'd0);

        // Drop counter saturates
        step(1, 1, 0, 0);
        repeat (4) step(0, 1, 0, 0);
        repeat (17) step(1, 1, 0, 0);
        chk("drop_saturate", 32'(bus.drop_count), 32'd15);
        step(0, 1, 1, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) == 0, int'($urandom_range(0, 3)),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 199) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
